// File: rtl/store_data_gen_pkg.sv
// Shared encodings for the MEM-stage load/store data paths: store type
// codes, bus transfer size codes and the store FSM state encoding.
package store_data_gen_pkg;

    // Store type codes as decoded by the pipeline
    localparam logic [2:0] ST_SW = 3'b000;
    localparam logic [2:0] ST_SH = 3'b001;
    localparam logic [2:0] ST_SB = 3'b010;

    // Bus transfer size codes
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Store FSM states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

endpackage

// File: rtl/store_data_gen_fmt.sv
// Pure combinational store formatter: lane replication, byte strobes,
// transfer size and alignment/legality checks for one store request.
module store_data_gen_fmt
    import store_data_gen_pkg::*;
(
    input  logic [2:0]  st_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_wdata,
    output logic [31:0] wdata,
    output logic [3:0]  wen,
    output logic [1:0]  size,
    output logic        misalign,
    output logic        illegal
);

    // Decode the store type into bus fields; illegal codes produce no strobes
    always_comb begin
        wdata    = 32'd0;
        wen      = 4'b0000;
        size     = SZ_WORD;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (st_type)
            ST_SW: begin
                wdata    = st_wdata;
                wen      = 4'b1111;
                size     = SZ_WORD;
                misalign = (addr_lo != 2'b00);
            end
            ST_SH: begin
                wdata    = {2{st_wdata[15:0]}};
                wen      = addr_lo[1] ? 4'b1100 : 4'b0011;
                size     = SZ_HALF;
                misalign = addr_lo[0];
            end
            ST_SB: begin
                wdata    = {4{st_wdata[7:0]}};
                wen      = 4'b0001 << addr_lo;
                size     = SZ_BYTE;
                misalign = 1'b0;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_data_gen.sv
// MEM-stage store engine: accepts SW/SH/SB, raises AdES on misalignment,
// and runs the write on the sram-like bus while stalling the pipeline.
// Bus handshake: data_req stays high with stable fields until data_addr_ok;
// the write completes on data_data_ok, which may coincide with data_addr_ok.
module store_data_gen
    import store_data_gen_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [2:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_wdata,
    input  logic        flush,
    output logic        st_exp,
    output logic [31:0] st_badvaddr,
    output logic        st_done,
    output logic        stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wen,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    output logic        bus_err
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] wait_cnt;
    logic [31:0] f_wdata;
    logic [3:0]  f_wen;
    logic [1:0]  f_size;
    logic        f_misalign;
    logic        f_illegal;
    logic        accept;
    logic        start;

    store_data_gen_fmt u_fmt (
        .st_type  (st_type),
        .addr_lo  (st_addr[1:0]),
        .st_wdata (st_wdata),
        .wdata    (f_wdata),
        .wen      (f_wen),
        .size     (f_size),
        .misalign (f_misalign),
        .illegal  (f_illegal)
    );

    assign accept      = (state == S_IDLE) && st_valid && !flush;
    assign st_exp      = accept && f_misalign;
    assign st_badvaddr = st_exp ? st_addr : 32'd0;
    assign start       = accept && !f_misalign && !f_illegal;
    assign data_req    = (state == S_REQ);
    assign data_wr     = data_req;

    // Next-state, completion pulse and pipeline stall
    always_comb begin
        state_nxt = state;
        st_done   = 1'b0;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_REQ;
                    stall     = 1'b1;
                end else if (accept && f_illegal) begin
                    st_done = 1'b1;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (data_addr_ok && data_data_ok) begin
                    state_nxt = S_IDLE;
                    st_done   = 1'b1;
                    stall     = 1'b0;
                end else if (data_addr_ok) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (data_data_ok) begin
                    state_nxt = S_IDLE;
                    st_done   = 1'b1;
                    stall     = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and request field latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            data_addr  <= 32'd0;
            data_wdata <= 32'd0;
            data_wen   <= 4'b0000;
            data_size  <= 2'd0;
        end else begin
            state <= state_nxt;
            if (start) begin
                data_addr  <= st_addr;
                data_wdata <= f_wdata;
                data_wen   <= f_wen;
                data_size  <= f_size;
            end
        end
    end

    // Watchdog: counts WAIT cycles and sets a sticky error at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 32'd0;
            bus_err  <= 1'b0;
        end else if (state == S_REQ && state_nxt == S_WAIT) begin
            wait_cnt <= 32'd0;
        end else if (state == S_WAIT) begin
            if (wait_cnt != 32'hFFFF_FFFF) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if (WAIT_LIMIT != 0 && (wait_cnt + 32'd1) >= 32'(WAIT_LIMIT)) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_data_gen.sv
// Directed bench for store_data_gen: inputs change just after the falling
// edge and outputs are checked 1ns later, away from the rising edge.
module tb_store_data_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [2:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic        flush;
    logic        st_exp;
    logic [31:0] st_badvaddr;
    logic        st_done;
    logic        stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wen;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        bus_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    store_data_gen #(.WAIT_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid     (st_valid),
        .st_type      (st_type),
        .st_addr      (st_addr),
        .st_wdata     (st_wdata),
        .flush        (flush),
        .st_exp       (st_exp),
        .st_badvaddr  (st_badvaddr),
        .st_done      (st_done),
        .stall        (stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wen     (data_wen),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .bus_err      (bus_err)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_type  = t;
        st_addr  = a;
        st_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; st_valid = 1'b0; st_type = 3'd0; st_addr = 32'd0; st_wdata = 32'd0;
        flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        repeat (2) tick();
        #1;
        vec_cnt++;
        if ({data_req, data_wr, st_done, bus_err, stall, st_exp} !== 6'b0) begin
            err_cnt++; $display("FAIL reset_ctl got %b want 000000", {data_req, data_wr, st_done, bus_err, stall, st_exp});
        end
        vec_cnt++;
        if ({data_size, data_addr, data_wdata, data_wen} !== 70'd0) begin
            err_cnt++; $display("FAIL reset_fields got size=%0d addr=%h wdata=%h wen=%b want all 0", data_size, data_addr, data_wdata, data_wen);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_sb_wait();
        tick(); issue(3'b010, 32'h0000_1003, 32'h0000_00A5); #1;
        vec_cnt++;
        if ({stall, st_exp, data_req} !== 3'b100) begin
            err_cnt++; $display("FAIL sb_accept got stall/exp/req=%b want 100", {stall, st_exp, data_req});
        end
        tick(); st_valid = 1'b0; data_addr_ok = 1'b1; #1;
        vec_cnt++;
        if ({data_req, data_wr, data_wen, data_size, stall, st_done} !== 10'b11_1000_00_1_0) begin
            err_cnt++; $display("FAIL sb_req got req=%b wr=%b wen=%b size=%0d stall=%b done=%b want 1 1 1000 0 1 0", data_req, data_wr, data_wen, data_size, stall, st_done);
        end
        vec_cnt++;
        if (data_wdata !== 32'hA5A5_A5A5 || data_addr !== 32'h0000_1003) begin
            err_cnt++; $display("FAIL sb_data got wdata=%h addr=%h want a5a5a5a5 00001003", data_wdata, data_addr);
        end
        tick(); data_addr_ok = 1'b0; #1;
        vec_cnt++;
        if ({data_req, data_wr, stall, st_done} !== 4'b0010) begin
            err_cnt++; $display("FAIL sb_wait1 got req/wr/stall/done=%b want 0010", {data_req, data_wr, stall, st_done});
        end
        tick(); data_data_ok = 1'b1; #1;
        vec_cnt++;
        if ({stall, st_done, data_req} !== 3'b010) begin
            err_cnt++; $display("FAIL sb_done got stall/done/req=%b want 010", {stall, st_done, data_req});
        end
        tick(); data_data_ok = 1'b0; #1;
        vec_cnt++;
        if ({stall, st_done, data_req} !== 3'b000) begin
            err_cnt++; $display("FAIL sb_idle got stall/done/req=%b want 000", {stall, st_done, data_req});
        end
    endtask

    task automatic test_sh_same_cycle();
        tick(); issue(3'b001, 32'h0000_2002, 32'h1234_BEEF); #1;
        vec_cnt++;
        if (stall !== 1'b1) begin
            err_cnt++; $display("FAIL sh_accept got stall=%b want 1", stall);
        end
        tick(); st_valid = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; #1;
        vec_cnt++;
        if ({data_req, data_wen, data_size, data_wdata} !== {1'b1, 4'b1100, 2'd1, 32'hBEEF_BEEF}) begin
            err_cnt++; $display("FAIL sh_req got req=%b wen=%b size=%0d wdata=%h want 1 1100 1 beefbeef", data_req, data_wen, data_size, data_wdata);
        end
        vec_cnt++;
        if ({st_done, stall} !== 2'b10) begin
            err_cnt++; $display("FAIL sh_done got done/stall=%b want 10", {st_done, stall});
        end
        tick(); data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
        vec_cnt++;
        if ({data_req, st_done, stall} !== 3'b000) begin
            err_cnt++; $display("FAIL sh_idle got req/done/stall=%b want 000", {data_req, st_done, stall});
        end
    endtask

    task automatic test_misalign();
        tick(); issue(3'b000, 32'h0000_3001, 32'hDEAD_BEEF); #1;
        vec_cnt++;
        if ({st_exp, stall, data_req, st_done} !== 4'b1000 || st_badvaddr !== 32'h0000_3001) begin
            err_cnt++; $display("FAIL sw_misalign got exp/stall/req/done=%b bad=%h want 1000 00003001", {st_exp, stall, data_req, st_done}, st_badvaddr);
        end
        tick(); issue(3'b001, 32'h0000_3003, 32'h0); #1;
        vec_cnt++;
        if ({st_exp, data_req} !== 2'b10 || st_badvaddr !== 32'h0000_3003) begin
            err_cnt++; $display("FAIL sh_misalign got exp/req=%b bad=%h want 10 00003003", {st_exp, data_req}, st_badvaddr);
        end
        flush = 1'b1; #1;
        vec_cnt++;
        if ({st_exp, stall} !== 2'b00 || st_badvaddr !== 32'd0) begin
            err_cnt++; $display("FAIL flush_block got exp/stall=%b bad=%h want 00 0", {st_exp, stall}, st_badvaddr);
        end
        tick(); flush = 1'b0; issue(3'b001, 32'h0000_3002, 32'h0); st_valid = 1'b0; #1;
        vec_cnt++;
        if ({data_req, st_exp} !== 2'b00) begin
            err_cnt++; $display("FAIL post_exp_idle got req/exp=%b want 00", {data_req, st_exp});
        end
        tick(); issue(3'b111, 32'h0000_3005, 32'h0); #1;
        vec_cnt++;
        if ({st_done, st_exp, stall} !== 3'b100) begin
            err_cnt++; $display("FAIL illegal_type got done/exp/stall=%b want 100", {st_done, st_exp, stall});
        end
        tick(); st_valid = 1'b0; #1;
        vec_cnt++;
        if ({data_req, st_done} !== 2'b00) begin
            err_cnt++; $display("FAIL illegal_idle got req/done=%b want 00", {data_req, st_done});
        end
    endtask

    task automatic test_req_hold();
        tick(); issue(3'b000, 32'h0000_4000, 32'hCAFE_F00D);
        tick(); st_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            #1;
            vec_cnt++;
            if ({data_req, stall, data_wen, data_size} !== {1'b1, 1'b1, 4'b1111, 2'd2} ||
                data_addr !== 32'h0000_4000 || data_wdata !== 32'hCAFE_F00D) begin
                err_cnt++; $display("FAIL req_hold[%0d] got req=%b stall=%b wen=%b size=%0d addr=%h wdata=%h want 1 1 1111 2 00004000 cafef00d",
                                    i, data_req, stall, data_wen, data_size, data_addr, data_wdata);
            end
            tick();
        end
        flush = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b1; #1;
        vec_cnt++;
        if ({st_done, stall} !== 2'b10) begin
            err_cnt++; $display("FAIL req_hold_done got done/stall=%b want 10", {st_done, stall});
        end
        tick(); flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    endtask

    task automatic test_watchdog();
        tick(); issue(3'b000, 32'h0000_5000, 32'h1111_2222);
        tick(); st_valid = 1'b0; data_addr_ok = 1'b1;
        tick(); data_addr_ok = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            vec_cnt++;
            if ({bus_err, stall} !== 2'b01) begin
                err_cnt++; $display("FAIL wdog_wait%0d got err/stall=%b want 01", i, {bus_err, stall});
            end
            tick();
        end
        #1;
        vec_cnt++;
        if ({bus_err, stall} !== 2'b11) begin
            err_cnt++; $display("FAIL wdog_rise got err/stall=%b want 11", {bus_err, stall});
        end
        data_data_ok = 1'b1; #1;
        vec_cnt++;
        if (st_done !== 1'b1) begin
            err_cnt++; $display("FAIL wdog_done got done=%b want 1", st_done);
        end
        tick(); data_data_ok = 1'b0; #1;
        vec_cnt++;
        if ({bus_err, data_req} !== 2'b10) begin
            err_cnt++; $display("FAIL wdog_sticky got err/req=%b want 10", {bus_err, data_req});
        end
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        vec_cnt++;
        if (bus_err !== 1'b0) begin
            err_cnt++; $display("FAIL wdog_clear got err=%b want 0", bus_err);
        end
    endtask

    task automatic test_rst_in_wait();
        tick(); issue(3'b000, 32'h0000_6000, 32'h3333_4444);
        tick(); st_valid = 1'b0; data_addr_ok = 1'b1;
        tick(); data_addr_ok = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0; data_data_ok = 1'b1; #1;
        vec_cnt++;
        if ({data_req, stall, st_done} !== 3'b000 || data_addr !== 32'd0) begin
            err_cnt++; $display("FAIL rst_wait got req/stall/done=%b addr=%h want 000 0", {data_req, stall, st_done}, data_addr);
        end
        tick(); data_data_ok = 1'b0; issue(3'b000, 32'h0000_6004, 32'h5555_6666);
        tick(); st_valid = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; #1;
        vec_cnt++;
        if ({data_req, st_done} !== 2'b11 || data_addr !== 32'h0000_6004 || data_wdata !== 32'h5555_6666) begin
            err_cnt++; $display("FAIL rst_after got req/done=%b addr=%h wdata=%h want 11 00006004 55556666", {data_req, st_done}, data_addr, data_wdata);
        end
        tick(); data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
        vec_cnt++;
        if ({data_req, stall} !== 2'b00) begin
            err_cnt++; $display("FAIL rst_after_idle got req/stall=%b want 00", {data_req, stall});
        end
    endtask

    task automatic test_sb_lanes();
        for (int a = 0; a < 4; a++) begin
            tick(); issue(3'b010, 32'h0000_7000 + 32'(a), 32'hFFFF_FF3C);
            tick(); st_valid = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; #1;
            vec_cnt++;
            if (data_wen !== (4'b0001 << a) || data_wdata !== 32'h3C3C_3C3C) begin
                err_cnt++; $display("FAIL sb_lane%0d got wen=%b wdata=%h want %b 3c3c3c3c", a, data_wen, data_wdata, 4'b0001 << a);
            end
            tick(); data_addr_ok = 1'b0; data_data_ok = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_sb_wait();
        test_sh_same_cycle();
        test_misalign();
        test_req_hold();
        test_sb_lanes();
        test_watchdog();
        test_rst_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/store_data_gen.md
Name: store_data_gen

Overview:
- Store-side counterpart of the load data path in the MEM stage.
- Accepts SW/SH/SB requests from the pipeline and checks alignment, raising AdES on a misaligned address.
- Formats write data by replicating byte/halfword across lanes, and builds byte enables and transfer size.
- Runs the transfer on the sram-like data bus (req / addr_ok / data_ok) and stalls the pipeline until the write is acknowledged.

Parameters:
- WAIT_LIMIT, 0, cycles allowed in WAIT before bus_err is raised; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store request present in MEM this cycle
- st_type  in  3  3'b000 SW, 3'b001 SH, 3'b010 SB; all other codes are illegal
- st_addr  in  32  effective address
- st_wdata  in  32  rt value; low byte/half is used for SB/SH
- flush  in  1  pipeline flush; blocks acceptance of a new store
- st_exp  out  1  address error on store (AdES), combinational
- st_badvaddr  out  32  faulting address; equals st_addr when st_exp=1, else 0
- st_done  out  1  one-cycle pulse when the write is acknowledged
- stall  out  1  holds the pipeline while a store is in flight
- data_req  out  1  bus request
- data_wr  out  1  constant 1 while data_req=1, else 0
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  latched full byte address
- data_wdata  out  32  lane-replicated write data
- data_wen  out  4  byte strobes
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  write complete
- bus_err  out  1  sticky watchdog flag

Behaviour:
- Reset: state=IDLE; data_req, data_wr, st_done, bus_err, data_size, data_addr, data_wdata, data_wen, wait counter all 0.
- FSM states: IDLE, REQ, WAIT.
- Formatting for SW:
  - wdata=st_wdata, wen=4'b1111, size=2.
  - Misaligned if addr[1:0]!=0.
- Formatting for SH:
  - wdata={2{st_wdata[15:0]}}, wen=addr[1]?4'b1100:4'b0011, size=1.
  - Misaligned if addr[0]=1.
- Formatting for SB:
  - wdata={4{st_wdata[7:0]}}, wen=4'b0001<<addr[1:0], size=0.
  - Never misaligned.
- Acceptance happens in IDLE when st_valid=1 and flush=0:
  - Misaligned: st_exp=1 the same cycle, st_badvaddr=st_addr, no bus request, state stays IDLE, stall=0.
  - Illegal st_type: no request and no exception; st_done pulses the same cycle (treated as no-op).
  - Legal and aligned: latch addr/wdata/wen/size, go to REQ next cycle; stall=1 in the accepting cycle.
- flush=1 in IDLE: nothing is accepted, st_exp=0.
- REQ:
  - data_req=1 with stable latched fields.
  - Stay in REQ until data_addr_ok=1.
  - addr_ok without data_ok: go to WAIT.
  - addr_ok and data_ok in the same cycle: st_done=1, return to IDLE.
- WAIT:
  - data_req=0.
  - On data_data_ok: st_done=1, return to IDLE.
- stall=1 in every REQ/WAIT cycle except the one where data_data_ok completes the transfer (the cycle with st_done=1).
- flush in REQ/WAIT is ignored: the request cannot be withdrawn, and st_done still pulses.
- Watchdog:
  - Counter clears on entry to WAIT and increments each WAIT cycle.
  - If WAIT_LIMIT!=0 and the count reaches WAIT_LIMIT, bus_err is set; it stays set until rst.
  - The FSM keeps waiting after bus_err is set.
- A store can be accepted at the earliest the cycle after st_done (one idle cycle between stores).
- rst mid-transaction: immediate return to IDLE with all outputs cleared; any outstanding data_ok is dropped.

Decomposition:
- Shared package holds:
  - st_type codes ST_SW/ST_SH/ST_SB, size codes SZ_BYTE/SZ_HALF/SZ_WORD, state encoding.
  - These sit next to the existing load-type codes.
- Natural sub-module: store_fmt, pure combinational. Maps (st_type, addr[1:0], st_wdata) to (wdata, wen, size, misalign, illegal). Verify it standalone against load-side lane selection.
- The FSM, latches and watchdog live in the top.

Test Plan:
- SB addr=0x1003, wdata=0x000000A5, addr_ok next cycle, data_ok 2 cycles later -> data_wen=4'b1000, data_wdata=0xA5A5A5A5, size=0, stall high until done, one st_done pulse.
- SH addr=0x2002, wdata=0x1234BEEF, addr_ok and data_ok same cycle as first req -> wen=4'b1100, wdata=0xBEEFBEEF, size=1, back in IDLE next cycle.
- SW addr=0x3001 -> st_exp=1, st_badvaddr=0x3001, data_req stays 0, stall=0; SH addr=0x3003 also gives st_exp=1.
- SW addr=0x4000, addr_ok held low 5 cycles -> data_req and fields stable for all 5 cycles; flush pulsed mid-REQ does not drop the req.
- WAIT_LIMIT=4, data_ok withheld -> bus_err rises after 4 WAIT cycles and stays high after a later data_ok; rst clears it.
- rst asserted in WAIT -> next cycle data_req=0, stall=0, st_done=0; a new SW immediately after completes normally.
